// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: operands are fed LSB-first through a single fulladd
// cell, one bit per clock, with the carry held in a flip-flop between bits.
module fulladd (
  input  logic Cin,
  input  logic x,
  input  logic y,
  output logic s,
  output logic Cout
);
  assign s    = x ^ y ^ Cin;
  assign Cout = (x & y) | (x & Cin) | (y & Cin);
endmodule

module serial_adder #(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         Busy,
  output logic         Done,
  output logic [N-1:0] Sum,
  output logic         Cout
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t        r_state;
  logic [N-1:0]  r_ra;
  logic [N-1:0]  r_rb;
  logic [N-1:0]  r_sum;
  logic          r_c;
  logic          r_cout;
  logic [CW-1:0] r_cnt;
  logic          w_s;
  logic          w_co;

  fulladd u_fa (
    .Cin  (r_c),
    .x    (r_ra[0]),
    .y    (r_rb[0]),
    .s    (w_s),
    .Cout (w_co)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_ra    <= '0;
      r_rb    <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_ra    <= A;
            r_rb    <= B;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          // Sum fills from the top so the first bit processed ends up at bit 0.
          r_ra  <= {1'b0, r_ra[N-1:1]};
          r_rb  <= {1'b0, r_rb[N-1:1]};
          r_sum <= {w_s, r_sum[N-1:1]};
          r_c   <= w_co;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_cout  <= w_co;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy = (r_state == S_ADD);
  assign Done = (r_state == S_DONE);
  assign Sum  = r_sum;
  assign Cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for protocol cases and a
// 4-bit instance swept exhaustively at the maximum issue rate.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst8, s8, rst4, s4;
  logic [7:0] a8, b8, sum8;
  logic [3:0] a4, b4, sum4;
  logic       busy8, done8, cout8, busy4, done4, cout4;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.N(8)) dut8 (
    .Clock(clk), .Reset(rst8), .Start(s8), .A(a8), .B(b8),
    .Busy(busy8), .Done(done8), .Sum(sum8), .Cout(cout8)
  );

  serial_adder #(.N(4)) dut4 (
    .Clock(clk), .Reset(rst4), .Start(s4), .A(a4), .B(b4),
    .Busy(busy4), .Done(done4), .Sum(sum4), .Cout(cout4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One 8-bit addition; optionally re-pulse Start or assert Reset on a given busy cycle.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] es,
                      input logic ec, input int repulse_at, input int reset_at);
    a8 = a; b8 = b; s8 = 1'b1;
    step();
    s8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    for (int i = 1; i <= 8; i++) begin
      if (i == reset_at) begin
        rst8 = 1'b1;
        step();
        rst8 = 1'b0;
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        for (int k = 0; k < 10; k++) begin
          chk("rst_nodone", done8, 0);
          step();
        end
        $display("add8 %02h+%02h interrupted by reset at cycle %0d", a, b, i);
        return;
      end
      chk("busy8", busy8, 1);
      chk("done8_early", done8, 0);
      if (i == repulse_at) begin
        s8 = 1'b1; a8 = 8'h01; b8 = 8'h01;
      end
      step();
      s8 = 1'b0;
    end
    chk("done8", done8, 1);
    chk("busy8_off", busy8, 0);
    chk("sum8", sum8, es);
    chk("cout8", cout8, ec);
    $display("add8 %02h+%02h -> sum=%02h cout=%0b", a, b, sum8, cout8);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("done8_once", done8, 0);
      chk("busy8_idle", busy8, 0);
      chk("sum8_hold", sum8, es);
      chk("cout8_hold", cout8, ec);
    end
  endtask

  initial begin
    logic [4:0] ref5;
    rst8 = 1'b1; s8 = 1'b0; a8 = '0; b8 = '0;
    rst4 = 1'b1; s4 = 1'b0; a4 = '0; b4 = '0;
    step(); step();
    rst8 = 1'b0;
    step();
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    chk("reset_sum", sum8, 0);
    chk("reset_cout", cout8, 0);

    run8(8'h00, 8'h00, 8'h00, 1'b0, 0, 0);
    run8(8'hFF, 8'h01, 8'h00, 1'b1, 0, 0);
    run8(8'hA5, 8'h5A, 8'hFF, 1'b0, 0, 0);
    run8(8'h80, 8'h80, 8'h00, 1'b1, 3, 0);
    run8(8'hFF, 8'hFF, 8'h00, 1'b0, 0, 4);
    run8(8'h0F, 8'h01, 8'h10, 1'b0, 0, 0);

    // Start and Reset together: reset wins, block stays idle
    rst8 = 1'b1; s8 = 1'b1; a8 = 8'h05; b8 = 8'h05;
    step();
    rst8 = 1'b0; s8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("sr_busy", busy8, 0);
      chk("sr_done", done8, 0);
      step();
    end
    chk("sr_sum", sum8, 0);
    $display("start+reset together -> busy=%0b sum=%02h", busy8, sum8);

    rst4 = 1'b0;
    step();
    for (int p = 0; p < 256; p++) begin
      a4 = 4'(p >> 4); b4 = 4'(p); s4 = 1'b1;
      ref5 = {1'b0, a4} + {1'b0, b4};
      step();
      s4 = 1'b0;
      for (int i = 1; i < 4; i++) begin
        chk("done4_early", done4, 0);
        step();
      end
      chk("done4_early", done4, 0);
      step();
      chk("done4", done4, 1);
      chk("sum4", sum4, ref5[3:0]);
      chk("cout4", cout4, ref5[4]);
      $display("add4 %0h+%0h -> sum=%0h cout=%0b", ref5 == ref5 ? a4 : a4, b4, sum4, cout4);
      step();
      chk("done4_off", done4, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
